// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter
//   Writeback arbiter for the FPU result path. Each FP execution unit fires a
//   single-cycle result pulse into its own one-entry buffer. The arbiter
//   serialises the buffered results onto the single FP register-file write
//   port through a registered output stage.
//
// Build option:
//   FP_WB_ARB_RR_EN  defined   -> round-robin grant. The search starts one past
//                                 the last granted source.
//                    undefined -> fixed priority. The lowest occupied index wins.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_src_valid      per-source result pulse (no backpressure)
//   i_src_result     per-source result, source k at [k*DATA_W +: DATA_W]
//   i_src_rd         per-source destination register, source k at [k*RD_W +: RD_W]
//   i_src_fflags     per-source exception flags (NV,DZ,OF,UF,NX), source k at [k*5 +: 5]
//   o_src_full       registered buffer-occupied bits; issue must not start unit k while set
//   o_wb_valid       writeback request
//   o_wb_data        writeback data
//   o_wb_rd          writeback destination register
//   o_wb_fflags      writeback flags
//   o_wb_src         index of the source currently on the output
//   i_wb_ready       write port accepts this cycle
//   o_overflow       sticky: a result arrived while its buffer could not take it
module fp_wb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_SRC-1:0]          i_src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   i_src_result,
  input  logic [NUM_SRC*RD_W-1:0]     i_src_rd,
  input  logic [NUM_SRC*5-1:0]        i_src_fflags,
  output logic [NUM_SRC-1:0]          o_src_full,
  output logic                        o_wb_valid,
  output logic [DATA_W-1:0]           o_wb_data,
  output logic [RD_W-1:0]             o_wb_rd,
  output logic [4:0]                  o_wb_fflags,
  output logic [$clog2(NUM_SRC)-1:0]  o_wb_src,
  input  logic                        i_wb_ready,
  output logic                        o_overflow
);

  localparam int IDX_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]             r_full;
  logic [NUM_SRC-1:0][DATA_W-1:0] r_data;
  logic [NUM_SRC-1:0][RD_W-1:0]   r_rd;
  logic [NUM_SRC-1:0][4:0]        r_fflags;

  logic              r_wbValid;
  logic [DATA_W-1:0] r_wbData;
  logic [RD_W-1:0]   r_wbRd;
  logic [4:0]        r_wbFflags;
  logic [IDX_W-1:0]  r_wbSrc;
  logic              r_overflow;

  logic               w_loadEn;
  logic               w_anyFull;
  logic [IDX_W-1:0]   w_grantIdx;
  logic [NUM_SRC-1:0] w_grantVec;

  // The output register may take a new result whenever it is empty or its
  // current result is being accepted by the write port.
  assign w_loadEn  = !r_wbValid || i_wb_ready;
  assign w_anyFull = |r_full;

`ifdef FP_WB_ARB_RR_EN
  // Last granted source. Resetting to NUM_SRC-1 makes the first search start at 0.
  logic [IDX_W-1:0] r_lastGrant;

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] candIdx;
    logic             found;
    w_grantIdx = '0;
    found      = 1'b0;
    cand       = 0;
    candIdx    = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      cand    = (int'(r_lastGrant) + 1 + off) % NUM_SRC;
      candIdx = IDX_W'(cand);
      if (!found && r_full[candIdx]) begin
        w_grantIdx = candIdx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lastGrant <= IDX_W'(NUM_SRC - 1);
    end else if (w_loadEn && w_anyFull) begin
      r_lastGrant <= w_grantIdx;
    end
  end
`else
  // Fixed priority. The descending scan leaves the lowest occupied index as the winner.
  always_comb begin
    w_grantIdx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (r_full[k]) begin
        w_grantIdx = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    w_grantVec = '0;
    if (w_loadEn && w_anyFull) begin
      w_grantVec[w_grantIdx] = 1'b1;
    end
  end

  // Source buffers. A granted buffer may be refilled on the same edge. A pulse
  // into an occupied, ungranted buffer is dropped and flagged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full     <= '0;
      r_data     <= '0;
      r_rd       <= '0;
      r_fflags   <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (i_src_valid[k] && (!r_full[k] || w_grantVec[k])) begin
          r_full[k]   <= 1'b1;
          r_data[k]   <= i_src_result[k*DATA_W +: DATA_W];
          r_rd[k]     <= i_src_rd[k*RD_W +: RD_W];
          r_fflags[k] <= i_src_fflags[k*5 +: 5];
        end else if (w_grantVec[k]) begin
          r_full[k] <= 1'b0;
        end
        if (i_src_valid[k] && r_full[k] && !w_grantVec[k]) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // Output stage. The payload fields keep their last value when nothing is
  // granted, so only the valid bit drops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wbValid  <= 1'b0;
      r_wbData   <= '0;
      r_wbRd     <= '0;
      r_wbFflags <= '0;
      r_wbSrc    <= '0;
    end else if (w_loadEn) begin
      if (w_anyFull) begin
        r_wbValid  <= 1'b1;
        r_wbData   <= r_data[w_grantIdx];
        r_wbRd     <= r_rd[w_grantIdx];
        r_wbFflags <= r_fflags[w_grantIdx];
        r_wbSrc    <= w_grantIdx;
      end else begin
        r_wbValid <= 1'b0;
      end
    end
  end

  assign o_src_full  = r_full;
  assign o_wb_valid  = r_wbValid;
  assign o_wb_data   = r_wbData;
  assign o_wb_rd     = r_wbRd;
  assign o_wb_fflags = r_wbFflags;
  assign o_wb_src    = r_wbSrc;
  assign o_overflow  = r_overflow;

endmodule
